// File: rtl/i2c_byte_sequencer.sv
`timescale 1ns/1ps
// I2C byte sequencer: paces SCL/SDA open-drain pull-downs through eight data bits
// plus the ACK bit and drives load/shift strobes for an external 8-bit shift register.
module i2c_byte_sequencer #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic cmd_write,
  input  logic cmd_read,
  input  logic ack_send,
  input  logic abort,
  input  logic sda_in,
  input  logic scl_in,
  input  logic sr_msb,
  output logic sr_load,
  output logic sr_shift,
  output logic sr_in_shift,
  output logic sr_inb,
  output logic scl_low,
  output logic sda_low,
  output logic busy,
  output logic done,
  output logic nack
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BIT  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [1:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [1:0] r_phase;
  logic [7:0] r_div_cnt;
  logic       r_is_write;
  logic       r_ack_send;
  logic       r_nack;
  logic       r_hold;

  logic w_in_bit;
  logic w_in_ack;
  logic w_stretch;
  logic w_tick;
  logic w_sample;
  logic w_bit_end;
  logic w_start;
  logic w_strobe_en;

  assign w_in_bit    = (r_state == S_BIT);
  assign w_in_ack    = (r_state == S_ACK);
  // A slave holding SCL low during the high half of a bit freezes the bit timer.
  assign w_stretch   = r_phase[1] & ~scl_in;
  assign w_tick      = (w_in_bit | w_in_ack) & (r_div_cnt == DIV_LAST) & ~w_stretch;
  assign w_sample    = w_tick & (r_phase == 2'd2);
  assign w_bit_end   = w_tick & (r_phase == 2'd3);
  assign w_start     = (r_state == S_IDLE) & (cmd_write | cmd_read) & ~abort;
  assign w_strobe_en = reset_n & ~abort;

  // NOTE: every register here uses non-blocking assignment so all of them update
  // together from values sampled at the same edge; blocking would create ordering races.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_phase    <= 2'd0;
      r_div_cnt  <= 8'd0;
      r_is_write <= 1'b0;
      r_ack_send <= 1'b0;
      r_nack     <= 1'b0;
      r_hold     <= 1'b0;
    end else if (abort) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_phase   <= 2'd0;
      r_div_cnt <= 8'd0;
      r_hold    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_BIT;
            r_is_write <= cmd_write;
            r_ack_send <= ack_send;
            r_bit_cnt  <= 3'd0;
            r_phase    <= 2'd0;
            r_div_cnt  <= 8'd0;
          end
        end
        S_BIT, S_ACK: begin
          if (w_tick) begin
            r_div_cnt <= 8'd0;
            r_phase   <= r_phase + 2'd1;
          end else if (!w_stretch) begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
          if (w_sample && w_in_ack && r_is_write) begin
            r_nack <= sda_in;
          end
          if (w_bit_end) begin
            if (w_in_ack) begin
              r_state <= S_DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state <= S_ACK;
              end
            end
          end
        end
        S_DONE: begin
          // Keep SCL low after a completed byte so the next byte can follow directly.
          r_state <= S_IDLE;
          r_hold  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: each output gets a default before the case; a path that skips an
  // assignment in always_comb would otherwise infer a latch.
  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (r_state)
      S_IDLE: scl_low = r_hold;
      S_BIT: begin
        scl_low = ~r_phase[1];
        sda_low = r_is_write ? ~sr_msb : 1'b0;
      end
      S_ACK: begin
        scl_low = ~r_phase[1];
        sda_low = r_is_write ? 1'b0 : r_ack_send;
      end
      S_DONE: scl_low = 1'b1;
      default: scl_low = 1'b0;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign nack        = r_nack;
  assign sr_load     = w_strobe_en & w_start & cmd_write;
  assign sr_shift    = w_strobe_en & w_in_bit & r_is_write & w_bit_end;
  assign sr_in_shift = w_strobe_en & w_in_bit & ~r_is_write & w_sample;
  assign sr_inb      = sr_in_shift & sda_in;

endmodule
